mlp_one_neuron: RTL and testbench

// - Fixed-point multilayer perceptron with a single time-multiplexed neuron (one MAC).
// - Evaluates M-1 fully connected layers of N neurons each over an N-wide input vector.
// - Standalone inference core; parameters and inputs are sampled by flags, results are held.

---
 rtl/mlp_pkg.sv | 30 +++
 rtl/mlp_mac_unit.sv | 61 ++++++
 rtl/mlp_one_neuron.sv | 139 +++++++++++++
 tb/tb_mlp_one_neuron.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared widths, fixed-point types and FSM encoding for the
// single-neuron MLP core.
package mlp_pkg;

  localparam int M  = 3;
  localparam int N  = 3;
  localparam int QM = 3;
  localparam int QN = 5;
  localparam int WM = 3;
  localparam int WN = 5;

  localparam int DW = QM + QN;
  localparam int PW = 2 * DW;
  localparam int AW = 2 * QM + WM + QN + WN;

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = (M > 2) ? $clog2(M - 1) : 1;

  typedef logic signed [DW-1:0] data_t;
  typedef logic signed [PW-1:0] prod_t;
  typedef logic signed [AW-1:0] acc_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_ACT,
    S_DONE
  } state_t;

endpackage

// File: rtl/mlp_mac_unit.sv
// Single MAC: multiply-accumulate, bias add, activation, floor and
// saturate. Optional ReLU when MLP_RELU_EN is defined.
module mlp_mac_unit
  import mlp_pkg::*;
(
  input  logic  clk,
  input  logic  nrst,
  input  logic  clr,
  input  logic  en,
  input  data_t a,
  input  data_t wt,
  input  data_t bias,
  output data_t result
);

  localparam int FW = AW - WN;

  prod_t prod;
  prod_t prod_sh;
  acc_t  acc;
  acc_t  prod_ext;
  acc_t  bias_ext;
  acc_t  sum;
  acc_t  act;
  logic  [FW-1:0] flr;
  logic  [FW-DW:0] hi;
  logic  ovf;

  assign prod     = PW'(a) * PW'(wt);
  assign prod_sh  = prod >>> (QN - WN);
  assign prod_ext = {{(AW-PW){prod_sh[PW-1]}}, prod_sh};
  assign bias_ext = {{(AW-DW-WN){bias[DW-1]}}, bias, {WN{1'b0}}};
  assign sum      = acc + bias_ext;

  // Activation, floor to QN fraction bits, then clamp to data range
  always_comb begin
`ifdef MLP_RELU_EN
    act = sum[AW-1] ? '0 : sum;
`else
    act = sum;
`endif
    flr = act[AW-1:WN];
    hi  = flr[FW-1:DW-1];
    ovf = !(&hi) && (|hi);
    if (ovf)
      result = {flr[FW-1], {(DW-1){~flr[FW-1]}}};
    else
      result = flr[DW-1:0];
  end

  // Accumulator: cleared per neuron, one product added per MAC cycle
  always_ff @(posedge clk) begin
    if (!nrst)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= acc + prod_ext;
  end

endmodule

// File: rtl/mlp_one_neuron.sv
// Time-multiplexed MLP: one MAC walks layers/neurons/inputs.
// Build with MLP_RELU_EN defined for ReLU activation.
module mlp_one_neuron
  import mlp_pkg::*;
(
  input  logic  clk,
  input  logic  nrst,
  input  logic  init,
  input  logic  initial_flag,
  input  logic  weight_flag,
  input  data_t x [N],
  input  data_t w [M-1][N][N],
  input  data_t b [M-1][N],
  output data_t outputs [N]
);

  localparam logic [NW-1:0] NLAST = NW'(N - 1);
  localparam logic [LW-1:0] LLAST = LW'(M - 2);
  localparam logic          OBANK = 1'((M - 2) % 2);

  state_t state;
  state_t nstate;

  logic [LW-1:0] lyr;
  logic [NW-1:0] nrn;
  logic [NW-1:0] inp;

  data_t xs [N];
  data_t ws [M-1][N][N];
  data_t bs [M-1][N];
  data_t lbuf [2][N];

  data_t opa;
  data_t opw;
  data_t opb;
  data_t res;

  logic mac_en;
  logic act_we;
  logic out_we;
  logic acc_clr;

  // State register
  always_ff @(posedge clk) begin
    if (!nrst)
      state <= S_IDLE;
    else
      state <= nstate;
  end

  // Next state; init restarts from any state
  always_comb begin
    nstate = state;
    if (init)
      nstate = S_MAC;
    else
      unique case (state)
        S_IDLE: nstate = S_IDLE;
        S_MAC:  nstate = (inp == NLAST) ? S_ACT : S_MAC;
        S_ACT:  nstate = (nrn == NLAST && lyr == LLAST) ? S_DONE : S_MAC;
        S_DONE: nstate = S_IDLE;
      endcase
  end

  // Datapath strobes decoded from state
  always_comb begin
    mac_en  = (state == S_MAC)  && !init;
    act_we  = (state == S_ACT)  && !init;
    out_we  = (state == S_DONE) && !init;
    acc_clr = init || (state == S_ACT);
  end

  // Layer / neuron / input counters
  always_ff @(posedge clk) begin
    if (!nrst || init) begin
      lyr <= '0;
      nrn <= '0;
      inp <= '0;
    end else if (mac_en) begin
      inp <= (inp == NLAST) ? '0 : inp + NW'(1);
    end else if (act_we) begin
      if (nrn == NLAST) begin
        nrn <= '0;
        if (lyr != LLAST)
          lyr <= lyr + LW'(1);
      end else begin
        nrn <= nrn + NW'(1);
      end
    end
  end

  // Input and parameter stores, loaded by their flags
  always_ff @(posedge clk) begin
    if (!nrst) begin
      xs <= '{default: '0};
      ws <= '{default: '0};
      bs <= '{default: '0};
    end else begin
      if (initial_flag)
        xs <= x;
      if (weight_flag) begin
        ws <= w;
        bs <= b;
      end
    end
  end

  // Operand select: layer 0 from x, later layers from previous bank
  always_comb begin
    opa = (lyr == '0) ? xs[inp] : lbuf[~lyr[0]][inp];
    opw = ws[lyr][nrn][inp];
    opb = bs[lyr][nrn];
  end

  mlp_mac_unit u_mac (
    .clk    (clk),
    .nrst   (nrst),
    .clr    (acc_clr),
    .en     (mac_en),
    .a      (opa),
    .wt     (opw),
    .bias   (opb),
    .result (res)
  );

  // Ping-pong layer buffers and held output register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      lbuf    <= '{default: '0};
      outputs <= '{default: '0};
    end else begin
      if (act_we)
        lbuf[lyr[0]][nrn] <= res;
      if (out_we)
        outputs <= lbuf[OBANK];
    end
  end

endmodule

// File: tb/tb_mlp_one_neuron.sv
// Bench for mlp_one_neuron: timeline reference model with
// per-cycle compare, directed cases and randomized runs.
module tb_mlp_one_neuron;
  import mlp_pkg::*;

  localparam int L    = (M - 1) * N * (N + 1) + 1;
  localparam int DMAX = (1 << (DW - 1)) - 1;
  localparam int DMIN = -(1 << (DW - 1));

  logic  clk = 1'b0;
  logic  nrst = 1'b0;
  logic  init = 1'b0;
  logic  initial_flag = 1'b0;
  logic  weight_flag = 1'b0;
  data_t x [N];
  data_t w [M-1][N][N];
  data_t b [M-1][N];
  data_t outputs [N];

  int n_cmp = 0;
  int n_bad = 0;
  int n_msg = 0;

  int m_x [N];
  int m_w [M-1][N][N];
  int m_b [M-1][N];
  int exp_out [N];
  int pend [N];
  int cnt = 0;
  bit started = 0;

  always #5 clk = ~clk;

  mlp_one_neuron dut (
    .clk          (clk),
    .nrst         (nrst),
    .init         (init),
    .initial_flag (initial_flag),
    .weight_flag  (weight_flag),
    .x            (x),
    .w            (w),
    .b            (b),
    .outputs      (outputs)
  );

  function automatic void model_run();
    int a [N];
    int nx [N];
    int s;
    foreach (a[i]) a[i] = m_x[i];
    for (int l = 0; l < M - 1; l++) begin
      for (int j = 0; j < N; j++) begin
        s = m_b[l][j] * (1 << WN);
        for (int k = 0; k < N; k++)
          s += (a[k] * m_w[l][j][k]) >>> (QN - WN);
        s = s >>> WN;
`ifdef MLP_RELU_EN
        if (s < 0) s = 0;
`endif
        if (s > DMAX) s = DMAX;
        if (s < DMIN) s = DMIN;
        nx[j] = s;
      end
      a = nx;
    end
    pend = a;
  endfunction

  // Reference timeline: what the outputs must hold after each edge
  initial forever begin
    @(posedge clk);
    started = 1;
    if (!nrst) begin
      foreach (m_x[i]) m_x[i] = 0;
      foreach (m_w[l, j, k]) m_w[l][j][k] = 0;
      foreach (m_b[l, j]) m_b[l][j] = 0;
      foreach (exp_out[i]) exp_out[i] = 0;
      cnt = 0;
    end else begin
      if (initial_flag)
        foreach (m_x[i]) m_x[i] = int'(x[i]);
      if (weight_flag) begin
        foreach (m_w[l, j, k]) m_w[l][j][k] = int'(w[l][j][k]);
        foreach (m_b[l, j]) m_b[l][j] = int'(b[l][j]);
      end
      if (init) begin
        model_run();
        cnt = L;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) exp_out = pend;
      end
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (started) begin
      for (int i = 0; i < N; i++) begin
        n_cmp++;
        if (outputs[i] !== data_t'(exp_out[i])) begin
          n_bad++;
          if (n_msg < 30) begin
            n_msg++;
            $display("FAIL cycle_out[%0d] t=%0t: got %h need %h",
                     i, $time, outputs[i], data_t'(exp_out[i]));
          end
        end
      end
    end
  end

  task automatic chk(string nm, data_t act, data_t expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h need %h", nm, act, expv);
    end
  endtask

  task automatic chk_all(string nm, data_t expv);
    for (int i = 0; i < N; i++) chk(nm, outputs[i], expv);
  endtask

  task automatic fill(data_t xv, data_t wv, data_t bv);
    foreach (x[i]) x[i] = xv;
    foreach (w[l, j, k]) w[l][j][k] = wv;
    foreach (b[l, j]) b[l][j] = bv;
  endtask

  task automatic wait_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fire(bit fx, bit fw);
    @(negedge clk);
    initial_flag = fx;
    weight_flag  = fw;
    init         = 1'b1;
    @(negedge clk);
    initial_flag = 1'b0;
    weight_flag  = 1'b0;
    init         = 1'b0;
  endtask

  initial begin
    fill(8'h00, 8'h00, 8'h00);
    wait_n(2);
    nrst = 1'b1;
    wait_n(1);
    chk_all("reset", 8'h00);

    fill(8'h10, 8'h10, 8'h10);
    fire(1, 1);
    wait_n(L - 1);
    chk_all("before_done", 8'h00);
    wait_n(1);
    chk_all("half_all", 8'h4C);
    chk("model_pin_half", data_t'(exp_out[0]), 8'h4C);

    fill(8'h33, 8'h55, 8'h77);
    wait_n(50);
    chk_all("idle_hold", 8'h4C);

    fill(8'h10, 8'h10, 8'h10);
    fire(1, 1);
    wait_n(9);
    nrst = 1'b0;
    wait_n(1);
    nrst = 1'b1;
    wait_n(40);
    chk_all("reset_midrun", 8'h00);

    fill(8'h70, 8'h70, 8'h70);
    fire(1, 1);
    wait_n(L);
    chk_all("saturate", 8'h7F);
    chk("model_pin_sat", data_t'(exp_out[1]), 8'h7F);

    fill(8'h10, 8'h10, 8'hC0);
    fire(1, 1);
    wait_n(L);
`ifdef MLP_RELU_EN
    chk_all("neg_bias", 8'h00);
    chk("model_pin_neg", data_t'(exp_out[2]), 8'h00);
`else
    chk_all("neg_bias", 8'h84);
    chk("model_pin_neg", data_t'(exp_out[2]), 8'h84);
`endif

    fill(8'h10, 8'h10, 8'h10);
    fire(1, 1);
    wait_n(10);
    foreach (x[i]) x[i] = 8'h00;
    fire(1, 0);
    wait_n(L - 1);
`ifdef MLP_RELU_EN
    chk_all("reinit_hold", 8'h00);
`else
    chk_all("reinit_hold", 8'h84);
`endif
    wait_n(1);
    chk_all("reinit", 8'h28);
    chk("model_pin_reinit", data_t'(exp_out[0]), 8'h28);

    repeat (40) begin
      foreach (x[i]) x[i] = data_t'($urandom);
      foreach (w[l, j, k]) w[l][j][k] = data_t'($urandom);
      foreach (b[l, j]) b[l][j] = data_t'($urandom);
      fire($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      wait_n($urandom_range(0, L + 5));
      if ($urandom_range(0, 9) == 0) begin
        nrst = 1'b0;
        wait_n(1);
        nrst = 1'b1;
      end
    end
    wait_n(L + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
